pipe_stage_skid: RTL
====================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 150, meaning the payload width in bits (ID/EX bundle: WB_EN, MEM_CMD, EXE_CMD, PC, Val1, Val2, Reg2, Dst, Src1, Src2, is_Immediate).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the statistics counter width.
REQ-003 The block SHALL have port clk, input, 1 bit, the clock.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-005 The block SHALL have port flush, input, 1 bit, a synchronous kill of all held entries.
REQ-006 The block SHALL have port freeze, input, 1 bit, a hold with no accept and no pop.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning the upstream payload is valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept this cycle.
REQ-009 The block SHALL have port in_data, input, DATA_W bits, the upstream payload.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning the downstream payload is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning downstream accepts this cycle.
REQ-012 The block SHALL have port out_data, output, DATA_W bits, the downstream payload.
REQ-013 The block SHALL have port occupancy, output, 2 bits, the number of held entries (0..2).

Function
REQ-014 Storage SHALL be two registers, main (drives out_data) and skid, controlled by states EMPTY, ONE and FULL.
REQ-015 Handshake terms:
- in_ready = (state!=FULL) & !freeze & !flush.
- out_valid = (state!=EMPTY) & !freeze & !flush.
- acc = in_valid & in_ready.
- pop = out_valid & out_ready.
REQ-016 EMPTY transitions: on acc, main<=in_data and go to ONE; otherwise stay in EMPTY.
REQ-017 ONE transitions:
- acc & !pop: skid<=in_data, go to FULL.
- acc & pop: main<=in_data, stay in ONE.
- !acc & pop: go to EMPTY.
- otherwise: hold.
REQ-018 FULL transitions: on pop, main<=skid and go to ONE; otherwise hold (in_ready=0 in FULL).
REQ-019 Latency SHALL be 1 cycle: data accepted at edge N SHALL appear on out_data after edge N when the block was EMPTY, or main was popped in the same cycle.
REQ-020 Data SHALL leave in acceptance order; no payload SHALL be dropped or duplicated.
REQ-021 The block SHALL sustain throughput of 1 transfer per cycle while out_ready=1.
REQ-022 A flush SHALL take priority over freeze, acc and pop: state<=EMPTY, main<=0, skid<=0, and nothing accepted that cycle.
REQ-023 A freeze SHALL hold all state and data unchanged and SHALL force in_ready=0 and out_valid=0.
REQ-024 In EMPTY, out_data SHALL be 0 after a reset or flush; otherwise it SHALL retain the last popped value.
REQ-025 occupancy SHALL be 0, 1 or 2 for EMPTY, ONE or FULL respectively.

Reset
REQ-026 On rst=1, asynchronously: state=EMPTY, main=0, skid=0, out_valid=0, occupancy=0, and all counters 0.
REQ-027 On rst=1, in_ready SHALL be 0; after release it SHALL be governed by REQ-015.
REQ-028 A reset asserted mid-transfer SHALL discard held entries without emitting them.

Configuration
REQ-029 Macro PIPE_STAGE_STATS_EN SHALL, when defined, add the following outputs, each saturating at all-ones:
- stall_cnt[CNT_W], counting cycles where in_valid & !in_ready.
- bubble_cnt[CNT_W], counting cycles where out_ready & !out_valid.
- flush_cnt[CNT_W], counting cycles where flush=1.
REQ-030 When PIPE_STAGE_STATS_EN is undefined, those ports and the counter logic SHALL be absent, and the rest of the behaviour SHALL be identical.

Verification (DATA_W=32)
REQ-031 Streaming: out_ready=1, send 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 on consecutive cycles one cycle later, and occupancy never exceeds 1.
REQ-032 Backpressure: out_ready=0, send 0xA1 then 0xA2 -> occupancy=2 and in_ready=0; raise out_ready -> 0xA1 then 0xA2 in order, with no loss.
REQ-033 Flush: in FULL state (0xB1, 0xB2), pulse flush one cycle -> next cycle occupancy=0, out_valid=0, out_data=0, and 0xB1/0xB2 never emitted.
REQ-034 Freeze: in ONE state (0xC1), hold freeze 3 cycles with in_valid=1 -> out_valid=0 and in_ready=0, state unchanged; after release, 0xC1 is emitted.
REQ-035 Async reset mid-stream: assert rst between clock edges while FULL -> immediately occupancy=0 and out_valid=0; with STATS_EN, counters read 0.
REQ-036 Stats: with STATS_EN, CNT_W=2, hold in_valid=1 while FULL for 5 cycles -> stall_cnt saturates at 3.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - two-entry skid-buffered pipeline stage with flush/freeze; optional PIPE_STAGE_STATS_EN stats counters
module pipe_stage_skid #(
    parameter int DATA_W = 150,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    // Encoding doubles as the entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              acc;
    logic              pop;

    // Handshake terms; reset also blocks acceptance while it is held.
    always_comb begin
        in_ready  = (state_q != FULL) && !freeze && !flush && !rst;
        out_valid = (state_q != EMPTY) && !freeze && !flush;
        acc       = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    assign out_data  = main_q;
    assign occupancy = state_q;

    // Next-state and data movement; flush wins over everything, freeze
    // holds because it forces acc and pop low.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (acc && !pop) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (acc && pop) begin
                        main_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and payload registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (out_ready && !out_valid && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule
